// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the multiplexed
// 7-segment display driver.
package seg7_pkg;

    localparam int SLOT_PHASES = 8;
    localparam int NUM_DIGITS  = 4;

    localparam logic [3:0] DIG_OFF = 4'b1111;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Segment order g,f,e,d,c,b,a; a 0 lights the segment (common anode).
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        pat = 7'h7F;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            4'hF: pat = 7'h0E;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex7(i_nibble);

endmodule

// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed 7-segment driver: per-frame shadow latch, slot/phase
// scanning, brightness PWM, dead-time blanking and leading-zero blanking.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int PHASE_LEN = 781,
    parameter int DEAD_CYC  = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] display_num,
    input  logic [3:0]  dp_in,
    input  logic        lzb,
    input  logic [2:0]  bright,
    output logic [3:0]  dig_sel,
    output logic [7:0]  seg
);

    localparam int SUB_W = $clog2(PHASE_LEN);
    localparam int PH_W  = $clog2(SLOT_PHASES);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(PHASE_LEN - 1);
    localparam logic [SUB_W-1:0] DEAD_V  = SUB_W'(DEAD_CYC);
    localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(SLOT_PHASES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [SUB_W-1:0]      r_sub;
    logic [PH_W-1:0]       r_ph;
    logic [IDX_W-1:0]      r_idx;
    logic [15:0]           r_num_s;
    logic [3:0]            r_dp_s;
    logic                  r_lzb_s;
    logic [2:0]            r_bright_s;
    logic [3:0]            r_dig_sel;
    logic [7:0]            r_seg;

    logic [3:0]            w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_blank;
    logic [3:0]            w_sel_nib;
    logic [6:0]            w_hex;
    logic                  w_lit;
    logic                  w_sub_wrap;
    logic                  w_ph_wrap;
    logic                  w_frame_end;
    logic [3:0]            w_dig_on;

    // Digit i is a leading zero when it and every higher digit are zero.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_nib[gi] = r_num_s[gi*4 +: 4];
        if (gi == 0) begin : g_units
            assign w_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_blank[gi] = r_lzb_s && (r_num_s[4*NUM_DIGITS-1:4*gi] == '0);
        end
    end

    assign w_sel_nib   = w_nib[r_idx];
    assign w_sub_wrap  = (r_sub == SUB_MAX);
    assign w_ph_wrap   = w_sub_wrap && (r_ph == PH_MAX);
    assign w_frame_end = w_ph_wrap && (r_idx == IDX_MAX);
    assign w_dig_on    = ~(4'b0001 << r_idx);

    assign w_lit = (r_ph <= r_bright_s)
                && !((r_ph == '0) && (r_sub < DEAD_V))
                && !w_blank[r_idx];

    seg7_hex_decode u_hex (
        .i_nibble (w_sel_nib),
        .o_seg    (w_hex)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub      <= '0;
            r_ph       <= '0;
            r_idx      <= '0;
            r_num_s    <= '0;
            r_dp_s     <= '0;
            r_lzb_s    <= 1'b0;
            r_bright_s <= 3'd7;
            r_dig_sel  <= DIG_OFF;
            r_seg      <= SEG_OFF;
        end else begin
            r_sub <= w_sub_wrap ? '0 : r_sub + SUB_W'(1);
            if (w_sub_wrap) begin
                r_ph <= w_ph_wrap ? '0 : r_ph + PH_W'(1);
            end
            if (w_ph_wrap) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            // Inputs are sampled only at the frame boundary so a frame never tears.
            if (w_frame_end) begin
                r_num_s    <= display_num;
                r_dp_s     <= dp_in;
                r_lzb_s    <= lzb;
                r_bright_s <= bright;
            end
            r_dig_sel <= w_lit ? w_dig_on : DIG_OFF;
            r_seg     <= w_lit ? {~r_dp_s[r_idx], w_hex} : SEG_OFF;
        end
    end

    assign dig_sel = r_dig_sel;
    assign seg     = r_seg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a frame-position reference model
// predicts every output cycle; a negedge monitor compares against the pins.
module tb_seg7_scan_display;

    localparam int PL    = 4;
    localparam int DC    = 1;
    localparam int SLOT  = 8 * PL;
    localparam int FRAME = 4 * SLOT;

    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int         target;
        logic [3:0] dig;
        logic [7:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] display_num = 16'h1A3F;
    logic [3:0]  dp_in = 4'h0;
    logic        lzb = 1'b0;
    logic [2:0]  bright = 3'd7;
    logic [3:0]  dig_sel;
    logic [7:0]  seg;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pos = 0;
    logic [15:0] sh_num = 16'h0;
    logic [3:0]  sh_dp = 4'h0;
    logic        sh_lzb = 1'b0;
    logic [2:0]  sh_bright = 3'd7;

    seg7_scan_display #(.PHASE_LEN(PL), .DEAD_CYC(DC)) dut (
        .clk         (clk),
        .rst         (rst),
        .display_num (display_num),
        .dp_in       (dp_in),
        .lzb         (lzb),
        .bright      (bright),
        .dig_sel     (dig_sel),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected pins for a frame position, from the display rules directly.
    function automatic logic [11:0] model_out(int p);
        int slot, w, ph;
        logic lit;
        logic [3:0] nib;
        slot = p / SLOT;
        w    = p % SLOT;
        ph   = w / PL;
        lit  = (ph <= int'(sh_bright)) && (w >= DC);
        if (sh_lzb && slot > 0 && (sh_num >> (4 * slot)) == 16'h0)
            lit = 1'b0;
        nib = sh_num[4*slot +: 4];
        if (!lit)
            return {4'hF, 8'hFF};
        return {~(4'b0001 << slot), ~sh_dp[slot], HEX[nib]};
    endfunction

    // Predict the outputs for the coming edge given current inputs, then advance.
    task automatic tick();
        exp_t e;
        logic [11:0] o;
        e.target = cyc + 1;
        if (rst) begin
            e.dig = 4'hF;
            e.seg = 8'hFF;
            pos = 0;
            sh_num = 16'h0; sh_dp = 4'h0; sh_lzb = 1'b0; sh_bright = 3'd7;
        end else begin
            o = model_out(pos);
            e.dig = o[11:8];
            e.seg = o[7:0];
            if (pos == FRAME - 1) begin
                sh_num = display_num; sh_dp = dp_in; sh_lzb = lzb; sh_bright = bright;
            end
            pos = (pos + 1) % FRAME;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic show(string what);
        $display("[cyc %0d pos %0d] %s: num=%h dp=%b lzb=%0d bright=%0d rst=%0d",
                 cyc, pos, what, display_num, dp_in, lzb, bright, rst);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            checks++;
            if ($countones(~dig_sel) > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d dig_sel got %b expected at most one low bit", cyc, dig_sel);
            end
            while (sb.size() > 0 && sb[0].target < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale cyc=%0d expectation for cyc %0d never compared", cyc, sb[0].target);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].target == cyc) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (dig_sel !== e.dig || seg !== e.seg) begin
                    errors++;
                    $display("FAIL pins cyc=%0d got dig_sel=%b seg=%h expected dig_sel=%b seg=%h",
                             cyc, dig_sel, seg, e.dig, e.seg);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        show("reset");
        run(3);
        rst = 1'b0;
        show("release");
        run(FRAME);                          // frame 0 shows 0000
        run(40);                             // frame 1 shows 1A3F
        display_num = 16'h2222; show("tear change");
        run(FRAME - 40);
        lzb = 1'b1; display_num = 16'h0042; show("lzb 0042");
        run(FRAME);                          // frame 2 shows 2222
        display_num = 16'h0000; show("lzb 0000");
        run(FRAME);                          // frame 3 shows 0042 blanked
        lzb = 1'b0; display_num = 16'h1A3F; bright = 3'd0; show("bright 0");
        run(FRAME);                          // frame 4 shows lone 0
        bright = 3'd3; show("bright 3");
        run(FRAME);                          // frame 5 at brightness 0
        bright = 3'd7; dp_in = 4'b0100; display_num = 16'h8888; show("dp 8888");
        run(FRAME);                          // frame 6 at brightness 3
        dp_in = 4'h0; display_num = 16'h1A3F; show("back to 1A3F");
        run(FRAME);                          // frame 7 shows 8.8 with dp on digit 2
        run(70);                             // frame 8 shows 1A3F
        rst = 1'b1; show("mid-frame reset");
        tick();
        rst = 1'b0; show("release");
        run(FRAME);                          // shows 0000 again
        run(FRAME);                          // shows 1A3F
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 4) begin
                case ($urandom_range(0, 3))
                    0: display_num = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
                    1: dp_in = 4'($urandom);
                    2: lzb = 1'($urandom);
                    default: bright = 3'($urandom);
                endcase
                show("random input");
            end else if (r == 4 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1; show("random reset");
                tick();
                rst = 1'b0;
            end
            tick();
        end
        run(2);
        @(negedge clk);
        checks++;
        if (sb.size() > 1) begin
            errors++;
            $display("FAIL drain got %0d pending expectations expected at most 1", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Consumer end of the keypad scanner's 16-bit `display_num` bus. Drives a 4-digit, common-anode, multiplexed 7-segment display with 4 hex digits.
- Captures the value once per frame (tear-free), then time-multiplexes the digits.
- Supports per-digit decimal points, optional leading-zero blanking, 8-level brightness PWM and a ghosting dead-time at each digit switch.

Parameters:
- PHASE_LEN, 781: clk cycles per brightness phase. One digit slot is 8 phases; a frame is 32 phases, about 1 kHz at 25 MHz.
- DEAD_CYC, 25: blanked cycles at the start of each digit slot. Must satisfy 1 <= DEAD_CYC < PHASE_LEN.

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  reset.
- display_num  in  16  hex digits: [15:12] thousands (digit 3) .. [3:0] units (digit 0).
- dp_in  in  4  decimal point enable per digit, bit i = digit i, active high.
- lzb  in  1  1 = blank leading zeros.
- bright  in  3  brightness 0..7; lit phases per slot = bright+1.
- dig_sel  out  4  digit enables, active low; bit i drives digit i.
- seg  out  8  segments, active low; [7] = dp, [6:0] = g,f,e,d,c,b,a.

Interface (already decided): one clock; reset is synchronous and active-high (clock `clk`, reset `rst`).

Behaviour:
- Counters:
  - `sub`: 0..PHASE_LEN-1.
  - `ph`: 0..7, advances when `sub` wraps.
  - `idx`: 0..3, advances when `ph` wraps 7->0; 3 wraps to 0.
  - Slot order is digit 0, 1, 2, 3.
- Frame latch: in the cycle where idx=3, ph=7, sub=PHASE_LEN-1, load shadow registers `num_s`, `dp_s`, `lzb_s`, `bright_s` from the inputs.
  - Input changes at any other time have no visible effect until the next frame.
- Digit lit condition: `(ph <= bright_s) && !(ph==0 && sub < DEAD_CYC) && !blank(idx)`.
- `blank(idx)` applies only when `lzb_s`=1:
  - digit 3 blanked when num_s[15:12]==0;
  - digit 2 blanked when num_s[15:8]==0;
  - digit 1 blanked when num_s[15:4]==0;
  - digit 0 is never blanked, so 0000 shows "0".
- Outputs are registered, with 1-cycle latency from counter state to pins.
  - When lit: dig_sel = ~(1<<idx); seg = {~dp_s[idx], hex7(num_s nibble idx)}.
  - When not lit: dig_sel = 4'b1111, seg = 8'hFF. At most one dig_sel bit is ever low.
- hex7 table, 7 bits g..a, active low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset (synchronous, `rst`=1 at a clk edge):
  - sub, ph, idx = 0; num_s, dp_s = 0; lzb_s = 0; bright_s = 7.
  - dig_sel = 4'b1111, seg = 8'hFF on the following cycle.
  - Reset asserted mid-slot or mid-frame aborts the frame immediately; the first frame after reset displays 0000.
- Brightness timing, per slot:
  - bright=7: lit cycles = 8*PHASE_LEN - DEAD_CYC.
  - bright=b: lit cycles = (b+1)*PHASE_LEN - DEAD_CYC.

Decomposition:
- Package `seg7_pkg`:
  - localparams SLOT_PHASES=8, NUM_DIGITS=4;
  - constant function `hex7` (the 16-entry table above);
  - blank pattern constants DIG_OFF=4'b1111, SEG_OFF=8'hFF.
- One sub-module `seg7_hex_decode`: combinational 4-bit to 7-bit decoder using `hex7`.
- Counters, shadow latch, lit logic and output registers live in the top module.

Test Plan (PHASE_LEN=4, DEAD_CYC=1, frame = 128 cycles):
1. Release reset, display_num=16'h1A3F, dp_in=0, lzb=0, bright=7.
   - Frame 0 shows 0000: each slot seg=C0.
   - Frame 1: slot 0 dig_sel=1110 seg=8E; slot 1 dig_sel=1101 seg=B0; slot 2 dig_sel=1011 seg=88; slot 3 dig_sel=0111 seg=F9.
   - First cycle of each slot is 1111/FF.
2. Tear check: change display_num from 1A3F to 2222 at cycle 40 of frame 1.
   - Frame 1 still shows 1A3F.
   - Frame 2 shows seg=A4 on all digits.
3. lzb=1, display_num=16'h0042 (latched).
   - Slots 3 and 2: dig_sel stays 1111 throughout.
   - Slot 1: seg=99. Slot 0: seg=A4.
   - With 16'h0000: only digit 0 lit, seg=C0.
4. Brightness:
   - bright=0: each slot has exactly 3 lit cycles (slot cycles 1..3); cycles 0 and 4..31 are 1111/FF.
   - bright=3: 15 lit cycles.
   - bright=7: 31 lit cycles.
5. dp_in=4'b0100, display_num=16'h8888: slot 2 seg=00; other slots seg=80.
6. Assert rst for 1 cycle at cycle 70 of a frame showing 1A3F.
   - Next cycle: dig_sel=1111, seg=FF.
   - Counters restart at slot 0.
   - The following frame shows 0000 until the next latch.
